gtxe2_chnl_rx_oob: RTL

- SATA OOB receive detector: the receiving end of the TX OOB generator (TXCOMINIT/TXCOMWAKE/TXCOMFINISH).
- Measures burst and gap durations on the squelch-level idle indication.
- Emits one-cycle RXCOMINITDET / RXCOMWAKEDET pulses and a filtered RXELECIDLE.
- Instantiated inside the RX channel path, clocked by the RX OOB sampling clock.

---
 rtl/gtxe2_chnl_rx_oob.sv | 124 ++++++++++++
 1 files changed

// File: rtl/gtxe2_chnl_rx_oob.sv
// gtxe2_chnl_rx_oob: SATA OOB receive detector timing squelch bursts/gaps into COMINIT/COMWAKE pulses
// Define GTXE2_CHNL_RX_OOB_STATS_EN to add the saturating oob_err_cnt output.
module gtxe2_chnl_rx_oob #(
  parameter logic [3:0] SATA_BURST_SEQ_LEN = 4'd4,
  parameter int BURST_MIN = 12,
  parameter int BURST_MAX = 20,
  parameter int WAKE_GAP_MIN = 12,
  parameter int WAKE_GAP_MAX = 20,
  parameter int INIT_GAP_MIN = 44,
  parameter int INIT_GAP_MAX = 52,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_idle,
  output logic RXELECIDLE,
  output logic RXCOMINITDET,
`ifdef GTXE2_CHNL_RX_OOB_STATS_EN
  output logic RXCOMWAKEDET,
  output logic [7:0] oob_err_cnt
`else
  output logic RXCOMWAKEDET
`endif
);
  localparam logic [CNT_W-1:0] B_MIN = CNT_W'(BURST_MIN);
  localparam logic [CNT_W-1:0] B_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] W_MIN = CNT_W'(WAKE_GAP_MIN);
  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(WAKE_GAP_MAX);
  localparam logic [CNT_W-1:0] I_MIN = CNT_W'(INIT_GAP_MIN);
  localparam logic [CNT_W-1:0] I_MAX = CNT_W'(INIT_GAP_MAX);
  typedef enum logic [2:0] {IDLE, BURST, GAP, ACTIVE, HOLD} state_t;
  typedef enum logic [1:0] {NONE, WAKE, INIT} seq_t;
  state_t state, state_n;
  seq_t seq, seq_n, gap_cls;
  logic s1, s2, lvl, init_n, wake_n, init_det, wake_det;
  logic [CNT_W-1:0] dur_cnt;
  logic [3:0] burst_cnt, burst_cnt_n;
  assign RXELECIDLE = s2;
  assign RXCOMINITDET = init_det;
  assign RXCOMWAKEDET = wake_det;
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      lvl <= 1'b1;
      dur_cnt <= '0;
      state <= IDLE;
      burst_cnt <= '0;
      seq <= NONE;
      init_det <= 1'b0;
      wake_det <= 1'b0;
    end else begin
      s1 <= rx_idle;
      s2 <= s1;
      lvl <= s2;
      dur_cnt <= (s2 != lvl) ? CNT_W'(1) : (&dur_cnt ? dur_cnt : dur_cnt + CNT_W'(1));
      state <= state_n;
      burst_cnt <= burst_cnt_n;
      seq <= seq_n;
      init_det <= init_n;
      wake_det <= wake_n;
    end
  end
  // dur_cnt holds the length of the level seen up to the previous edge, so on a level change it is the finished element's length
  always_comb begin
    gap_cls = (dur_cnt >= W_MIN && dur_cnt <= W_MAX) ? WAKE :
              (dur_cnt >= I_MIN && dur_cnt <= I_MAX) ? INIT : NONE;
    state_n = state;
    burst_cnt_n = burst_cnt;
    seq_n = seq;
    init_n = 1'b0;
    wake_n = 1'b0;
    case (state)
      IDLE: state_n = s2 ? IDLE : BURST;
      BURST: begin
        if (!s2 && dur_cnt > B_MAX) begin
          state_n = ACTIVE;
          burst_cnt_n = '0;
          seq_n = NONE;
        end else if (s2 && dur_cnt >= B_MIN) begin
          state_n = GAP;
          burst_cnt_n = burst_cnt + 4'd1;
        end else if (s2) begin
          state_n = IDLE;
          burst_cnt_n = '0;
          seq_n = NONE;
        end
      end
      GAP: begin
        if (s2) begin
          if (burst_cnt == SATA_BURST_SEQ_LEN && seq != NONE && dur_cnt == (seq == INIT ? I_MIN : W_MIN)) begin
            init_n = seq == INIT;
            wake_n = seq == WAKE;
            state_n = HOLD;
            burst_cnt_n = '0;
            seq_n = NONE;
          end else if (dur_cnt > I_MAX) begin
            state_n = IDLE;
            burst_cnt_n = '0;
            seq_n = NONE;
          end
        end else begin
          state_n = BURST;
          if (gap_cls == NONE || (seq != NONE && gap_cls != seq)) begin
            burst_cnt_n = '0;
            seq_n = NONE;
          end else seq_n = gap_cls;
        end
      end
      ACTIVE, HOLD: state_n = (s2 && dur_cnt > I_MAX) ? IDLE : state;
      default: state_n = IDLE;
    endcase
  end
`ifdef GTXE2_CHNL_RX_OOB_STATS_EN
  // A GAP->BURST move that clears burst_cnt is exactly an unclassified or mismatched gap
  logic err;
  assign err = (state == BURST && (state_n == ACTIVE || state_n == IDLE)) ||
               (state == GAP && ((state_n == BURST && burst_cnt_n == '0) || (state_n == IDLE && burst_cnt != '0)));
  always_ff @(posedge clk) begin
    if (!reset) oob_err_cnt <= '0;
    else if (err && !(&oob_err_cnt)) oob_err_cnt <= oob_err_cnt + 8'd1;
  end
`endif
endmodule
